qtr_array_reader: RTL

Parametrised reflectance-sensor array front end for the line follower. It charges and releases an N-channel RC (QTR-type) sensor bus, measures each channel's discharge time in microsecond ticks, and computes a thresholded weighted-average line position. It also reports whether a line was found at all. The block sits between the sensor pins and the PD controller: `done` starts the controller update, and `pos` feeds the error computation. The `qt` vector feeds telemetry.

---
 rtl/qtr_array_reader.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/qtr_array_reader.sv
// qtr_array_reader: RC reflectance-sensor array front end.
// Charges the sensor bus, times each channel's discharge in microsecond
// ticks, then forms a thresholded weighted-average line position with a
// restoring divider.
// Optional feature macro: QTR_LAST_SIDE_EN. When defined, a last-side flag
// is remembered and a lost line snaps pos to the matching edge. When not
// defined, a lost line leaves pos unchanged.
// Handshake: start is a one-cycle request and is taken only in IDLE.
// busy is high from the cycle after start until DONE. done pulses for one
// cycle, and qt/pos/line_found are valid and stable from that cycle.
module qtr_array_reader #(
  parameter int N          = 8,
  parameter int TW         = 8,
  parameter int CHARGE_CYC = 120,
  parameter int TICK_DIV   = 12,
  parameter int THRESH     = 50
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  inout  wire  [N-1:0]    D,
  output logic [N*TW-1:0] qt,
  output logic [10:0]     pos,
  output logic            line_found,
  output logic            busy,
  output logic            done
);

  localparam int WW  = TW + $clog2(N);          // weight accumulator width
  localparam int SW  = WW + 8;                  // weighted-sum width
  localparam int IW  = $clog2(N);
  localparam int CW  = $clog2(CHARGE_CYC + 1);
  localparam int DW  = $clog2(TICK_DIV + 1);
  localparam int DCW = $clog2(SW + 1);
  localparam logic [TW-1:0] CNT_MAX = {TW{1'b1}};
  localparam logic [TW-1:0] THR     = TW'(THRESH);
  localparam logic [10:0]   POS_MAX = 11'(16 * (N - 1));
`ifdef QTR_LAST_SIDE_EN
  localparam logic [10:0]   POS_MID = 11'(8 * (N - 1));
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_CHARGE, S_SAMPLE, S_ACCUM, S_DIVIDE, S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          ch_cnt_q, ch_cnt_d;
  logic [DW-1:0]          div_q, div_d;
  logic [TW-1:0]          tick_q, tick_d;
  logic [N-1:0]           sync1_q, sync2_q;
  logic [N-1:0]           latched_q, latched_d;
  logic [N-1:0][TW-1:0]   meas_q, meas_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [WW-1:0]          wacc_q, wacc_d;
  logic [SW-1:0]          sacc_q, sacc_d;
  logic [WW:0]            rem_q, rem_d;
  logic [SW-1:0]          quo_q, quo_d;
  logic [DCW-1:0]         dcnt_q, dcnt_d;
  logic [N*TW-1:0]        qt_q, qt_d;
  logic [10:0]            pos_q, pos_d;
  logic                   lf_q, lf_d;
`ifdef QTR_LAST_SIDE_EN
  logic                   side_q, side_d;   // 1 = right, 0 = left
`endif

  // Combinational helpers
  logic [N-1:0]  fall;
  logic [TW-1:0] w_cur;
  logic [SW-1:0] term;
  logic [WW:0]   rem_sh;
  logic [WW+1:0] diff;
  logic [WW:0]   rem_nxt;
  logic [SW-1:0] quo_nxt;
  logic [10:0]   pos_nl;

  // Bus is driven high only while charging; released otherwise
  assign D = (state_q == S_CHARGE) ? {N{1'b1}} : {N{1'bz}};

  assign qt         = qt_q;
  assign pos        = pos_q;
  assign line_found = lf_q;
  assign busy       = (state_q == S_CHARGE) || (state_q == S_SAMPLE) ||
                      (state_q == S_ACCUM)  || (state_q == S_DIVIDE);
  assign done       = (state_q == S_DONE);

  // Two-flop synchroniser for the asynchronous sensor inputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= D;
      sync2_q <= sync1_q;
    end
  end

  // Datapath helpers: per-channel fall detect, weighting term, divider step
  always_comb begin
    fall    = ~sync2_q & ~latched_q;
    w_cur   = (meas_q[idx_q] >= THR) ? meas_q[idx_q] : '0;
    term    = (SW'(idx_q) * SW'(w_cur)) << 4;
    rem_sh  = {rem_q[WW-1:0], quo_q[SW-1]};
    diff    = {1'b0, rem_sh} - {2'b00, wacc_q};
    rem_nxt = diff[WW+1] ? rem_sh : diff[WW:0];
    quo_nxt = {quo_q[SW-2:0], ~diff[WW+1]};
`ifdef QTR_LAST_SIDE_EN
    pos_nl  = side_q ? POS_MAX : 11'd0;
`else
    pos_nl  = pos_q;
`endif
  end

  // Next-state and datapath update for the measurement sequence
  always_comb begin
    state_d   = state_q;
    ch_cnt_d  = ch_cnt_q;
    div_d     = div_q;
    tick_d    = tick_q;
    latched_d = latched_q;
    meas_d    = meas_q;
    idx_d     = idx_q;
    wacc_d    = wacc_q;
    sacc_d    = sacc_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dcnt_d    = dcnt_q;
    qt_d      = qt_q;
    pos_d     = pos_q;
    lf_d      = lf_q;
`ifdef QTR_LAST_SIDE_EN
    side_d    = side_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_CHARGE;
          ch_cnt_d = '0;
        end
      end
      S_CHARGE: begin
        if (ch_cnt_q == CW'(CHARGE_CYC - 1)) begin
          state_d   = S_SAMPLE;
          div_d     = '0;
          tick_d    = '0;
          latched_d = '0;
        end else begin
          ch_cnt_d = ch_cnt_q + 1'b1;
        end
      end
      S_SAMPLE: begin
        // First low reading latches the current tick; later edges ignored
        for (int i = 0; i < N; i++) begin
          if (fall[i]) meas_d[i] = tick_q;
        end
        latched_d = latched_q | fall;
        if (tick_q == CNT_MAX) begin
          // Channels still high at saturation read as full scale
          for (int i = 0; i < N; i++) begin
            if (!latched_q[i]) meas_d[i] = CNT_MAX;
          end
        end
        if ((&(latched_q | fall)) || (tick_q == CNT_MAX)) begin
          state_d = S_ACCUM;
          idx_d   = '0;
          wacc_d  = '0;
          sacc_d  = '0;
        end else if (div_q == DW'(TICK_DIV - 1)) begin
          div_d  = '0;
          tick_d = tick_q + 1'b1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_ACCUM: begin
        wacc_d = wacc_q + WW'(w_cur);
        sacc_d = sacc_q + term;
        if (idx_q == IW'(N - 1)) begin
          state_d = S_DIVIDE;
          rem_d   = '0;
          quo_d   = sacc_q + term;
          dcnt_d  = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DIVIDE: begin
        if (wacc_q == '0) begin
          state_d = S_DONE;
          lf_d    = 1'b0;
          pos_d   = pos_nl;
          qt_d    = meas_q;
        end else begin
          rem_d  = rem_nxt;
          quo_d  = quo_nxt;
          dcnt_d = dcnt_q + 1'b1;
          if (dcnt_q == DCW'(SW - 1)) begin
            state_d = S_DONE;
            lf_d    = 1'b1;
            pos_d   = quo_nxt[10:0];
            qt_d    = meas_q;
`ifdef QTR_LAST_SIDE_EN
            side_d  = (quo_nxt[10:0] >= POS_MID);
`endif
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      ch_cnt_q  <= '0;
      div_q     <= '0;
      tick_q    <= '0;
      latched_q <= '0;
      meas_q    <= '0;
      idx_q     <= '0;
      wacc_q    <= '0;
      sacc_q    <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dcnt_q    <= '0;
      qt_q      <= '0;
      pos_q     <= '0;
      lf_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_cnt_q  <= ch_cnt_d;
      div_q     <= div_d;
      tick_q    <= tick_d;
      latched_q <= latched_d;
      meas_q    <= meas_d;
      idx_q     <= idx_d;
      wacc_q    <= wacc_d;
      sacc_q    <= sacc_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dcnt_q    <= dcnt_d;
      qt_q      <= qt_d;
      pos_q     <= pos_d;
      lf_q      <= lf_d;
    end
  end

`ifdef QTR_LAST_SIDE_EN
  // Last-side memory; reset clears it to left
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) side_q <= 1'b0;
    else      side_q <= side_d;
  end
`endif

endmodule
